// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - synchronous AXI-Stream FIFO with single-cycle flush
//
// Purpose: buffers TDATA_WIDTH-bit stream words between fetch and decode.
// The FIFO keeps strict order and never bypasses storage combinationally.
// A pipeline redirect (invalidate) discards all contents in one cycle.
// Optional feature macro: AXIS_FIFO_LEVEL_EN adds the `level` occupancy output.
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   sif_tvalid  upstream word valid
//   sif_tdata   upstream word
//   sif_tready  FIFO accepts a word this cycle
//   mif_tvalid  head word valid
//   mif_tdata   head word (don't-care while mif_tvalid=0)
//   mif_tready  downstream accepts the head word
//   invalidate  flush all buffered words
//   level       occupancy 0..DEPTH (AXIS_FIFO_LEVEL_EN only)

module axis_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sif_tvalid,
  input  logic [TDATA_WIDTH-1:0]   sif_tdata,
  output logic                     sif_tready,
  output logic                     mif_tvalid,
  output logic [TDATA_WIDTH-1:0]   mif_tdata,
  input  logic                     mif_tready,
`ifdef AXIS_FIFO_LEVEL_EN
  input  logic                     invalidate,
  output logic [$clog2(DEPTH):0]   level
`else
  input  logic                     invalidate
`endif
);

  // Pointer width carries one extra wrap bit above the storage index.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [TDATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (wptr_q == rptr_q);
  // Same slot, different lap: the writer is a full ring ahead of the reader.
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[PW-1] != rptr_q[PW-1]);

  // Readiness is deliberately independent of mif_tready, so a full FIFO
  // refuses a push even in a cycle where the head is popped.
  assign sif_tready = !full  && !invalidate && !rst;
  assign mif_tvalid = !empty && !invalidate && !rst;
  assign mif_tdata  = mem_q[rptr_q[AW-1:0]];

  assign push = sif_tvalid && sif_tready;
  assign pop  = mif_tvalid && mif_tready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    // push/pop are already forced low by invalidate, so flushing is simply
    // snapping the reader onto the writer.
    if (invalidate) begin
      rptr_d = wptr_q;
    end else if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; push is already gated by rst and invalidate.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= sif_tdata;
    end
  end

`ifdef AXIS_FIFO_LEVEL_EN
  // Modulo-2*DEPTH difference yields 0..DEPTH directly from the pointers.
  assign level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - self-checking bench for axis_fifo against a queue model

module tb_axis_fifo;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk;
  logic          rst;
  logic          sif_tvalid;
  logic [W-1:0]  sif_tdata;
  logic          sif_tready;
  logic          mif_tvalid;
  logic [W-1:0]  mif_tdata;
  logic          mif_tready;
  logic          invalidate;
  logic [$clog2(D):0] level;

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO contents as an ordered list of words.
  logic [W-1:0] model_q [$];

  axis_fifo #(.TDATA_WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .sif_tvalid (sif_tvalid),
    .sif_tdata  (sif_tdata),
    .sif_tready (sif_tready),
    .mif_tvalid (mif_tvalid),
    .mif_tdata  (mif_tdata),
    .mif_tready (mif_tready),
`ifdef AXIS_FIFO_LEVEL_EN
    .invalidate (invalidate),
    .level      (level)
`else
    .invalidate (invalidate)
`endif
  );

`ifndef AXIS_FIFO_LEVEL_EN
  assign level = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model's view,
  // then advance the model by the same rules at the clock edge.
  task automatic cycle(input string tag, input logic r, input logic inv,
                       input logic sv, input logic [W-1:0] sd, input logic mr);
    logic exp_rdy;
    logic exp_vld;
    rst        = r;
    invalidate = inv;
    sif_tvalid = sv;
    sif_tdata  = sd;
    mif_tready = mr;
    #1;
    exp_rdy = !r && !inv && (model_q.size() < D);
    exp_vld = !r && !inv && (model_q.size() > 0);
    check({tag, ".sif_tready"}, W'(sif_tready), W'(exp_rdy));
    check({tag, ".mif_tvalid"}, W'(mif_tvalid), W'(exp_vld));
    if (exp_vld) check({tag, ".mif_tdata"}, mif_tdata, model_q[0]);
`ifdef AXIS_FIFO_LEVEL_EN
    if (!r) check({tag, ".level"}, W'(level), W'(model_q.size()));
`endif
    @(posedge clk);
    if (r || inv) begin
      model_q.delete();
    end else begin
      if (exp_vld && mr) void'(model_q.pop_front());
      if (exp_rdy && sv) model_q.push_back(sd);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; invalidate = 1'b0; sif_tvalid = 1'b0; sif_tdata = '0; mif_tready = 1'b0;

    // Reset release
    for (int i = 0; i < 3; i++) cycle("reset", 1, 0, 0, 0, 0);
    cycle("post_reset", 0, 0, 0, 0, 0);

    // Fill to full with the consumer stalled
    cycle("fill0", 0, 0, 1, 32'h11, 0);
    cycle("fill1", 0, 0, 1, 32'h22, 0);
    cycle("fill2", 0, 0, 1, 32'h33, 0);
    cycle("fill3", 0, 0, 1, 32'h44, 0);
    cycle("full_idle", 0, 0, 0, 0, 0);

    // Full while popping: only the pop happens, then 0x55 gets in
    cycle("full_pop", 0, 0, 1, 32'h55, 1);
    cycle("push55", 0, 0, 1, 32'h55, 0);

    // Drain: 0x22, 0x33, 0x44, 0x55, then empty
    for (int i = 0; i < 5; i++) cycle("drain", 0, 0, 0, 0, 1);

    // Streaming across several pointer wraps
    for (int i = 0; i < 20; i++) cycle("stream", 0, 0, 1, W'(i), 1);
    cycle("stream_tail", 0, 0, 0, 0, 1);
    cycle("stream_empty", 0, 0, 0, 0, 1);

    // Invalidate mid-stream with an incoming word
    cycle("inv_fill0", 0, 0, 1, 32'hA1, 0);
    cycle("inv_fill1", 0, 0, 1, 32'hA2, 0);
    cycle("inv_fill2", 0, 0, 1, 32'hA3, 0);
    cycle("inv", 0, 1, 1, 32'hAA, 0);
    cycle("inv_push_bb", 0, 0, 1, 32'hBB, 0);
    cycle("inv_head_bb", 0, 0, 0, 0, 1);
    cycle("inv_empty", 0, 0, 0, 0, 1);

    // Held invalidate keeps it closed
    cycle("inv_hold0", 0, 1, 1, 32'hC1, 1);
    cycle("inv_hold1", 0, 1, 1, 32'hC2, 1);
    cycle("inv_after", 0, 0, 0, 0, 0);

    // Reset mid-operation
    cycle("rm_fill0", 0, 0, 1, 32'hD1, 0);
    cycle("rm_fill1", 0, 0, 1, 32'hD2, 0);
    cycle("rm_rst", 1, 0, 1, 32'hD3, 1);
    cycle("rm_after", 0, 0, 0, 0, 1);
    cycle("rm_after2", 0, 0, 0, 0, 1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      logic r, inv, sv, mr;
      r   = ($urandom_range(0, 63) == 0);
      inv = ($urandom_range(0, 31) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 2) != 0);
      cycle("random", r, inv, sv, $urandom(), mr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
